// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, control encodings and data-memory geometry
package mips_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int LANES = DATA_WIDTH / 8;
  localparam logic CTRL_REG_WRITE_DIS = 1'b0;
  localparam logic CTRL_MEM_TO_REG_ALU = 1'b0;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);
endpackage

// File: rtl/data_memory.sv
// data_memory: word-wide RAM with byte-enable write, registered pipeline read and registered debug read
module data_memory
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [LANES-1:0]      be,
  input  logic [DMEM_AW-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DMEM_AW-1:0]    raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [DMEM_AW-1:0]    dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);
  logic [DATA_WIDTH-1:0] mem [DMEM_DEPTH];
  // byte-lane writes and pipeline read; contents are never reset, reads see pre-write data
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (we && be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    rdata <= mem[raddr];
  end
  // debug port samples the word every cycle, cleared while in reset
  always_ff @(posedge clk) begin
    if (reset) dbg_data <= '0;
    else dbg_data <= mem[dbg_addr];
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage with alignment checking, load extraction and MEM/WB registers
module mem_stage
  import mips_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     read_data_2_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
  input  logic                      reg_write_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      mem_to_reg_in,
  input  logic                      is_jal_in,
  input  logic [DATA_WIDTH-1:0]     pc_plus_4_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_unsigned_in,
  input  logic [DMEM_AW-1:0]        dbg_addr_in,
  output logic [DATA_WIDTH-1:0]     dbg_data_out,
  output logic [DATA_WIDTH-1:0]     wb_write_data_out,
  output logic [REG_ADDR_WIDTH-1:0] wb_write_register_out,
  output logic                      wb_reg_write_out,
  output logic [DATA_WIDTH-1:0]     mem_fwd_data_out,
  output logic                      misaligned_out
);
  logic [1:0] off;
  logic mis;
  logic we;
  logic [LANES-1:0] be;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] pass_q;
  logic sel_ld_q;
  logic [1:0] off_q;
  logic [1:0] size_q;
  logic uns_q;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [DATA_WIDTH-1:0] ld;
  // alignment check, lane enables and replicated store data for the current access
  always_comb begin
    off = alu_result_in[1:0];
    mis = (mem_read_in || mem_write_in) &&
          (mem_size_in == 2'b11 || (mem_size_in == MEM_SIZE_HALF && off[0]) ||
           (mem_size_in == MEM_SIZE_WORD && off != 2'b00));
    we = mem_write_in && !mis && !reset;
    be = mem_size_in == MEM_SIZE_BYTE ? 4'b0001 << off :
         mem_size_in == MEM_SIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = mem_size_in == MEM_SIZE_BYTE ? {4{read_data_2_in[7:0]}} :
            mem_size_in == MEM_SIZE_HALF ? {2{read_data_2_in[15:0]}} : read_data_2_in;
    mem_fwd_data_out = is_jal_in ? pc_plus_4_in : alu_result_in;
  end
  data_memory u_dmem (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .be       (be),
    .waddr    (alu_result_in[DMEM_AW+1:2]),
    .wdata    (wdata),
    .raddr    (alu_result_in[DMEM_AW+1:2]),
    .rdata    (rdata),
    .dbg_addr (dbg_addr_in),
    .dbg_data (dbg_data_out)
  );
  // MEM/WB register: JAL/ALU value is resolved early, load selection waits for the RAM word
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q <= '0;
      sel_ld_q <= 1'b0;
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      wb_write_register_out <= '0;
      wb_reg_write_out <= CTRL_REG_WRITE_DIS;
      misaligned_out <= 1'b0;
    end else begin
      pass_q <= is_jal_in ? pc_plus_4_in : alu_result_in;
      sel_ld_q <= !is_jal_in && mem_to_reg_in != CTRL_MEM_TO_REG_ALU;
      off_q <= off;
      size_q <= mem_size_in;
      uns_q <= mem_unsigned_in;
      wb_write_register_out <= write_register_in;
      wb_reg_write_out <= mis ? CTRL_REG_WRITE_DIS : reg_write_in;
      misaligned_out <= mis;
    end
  end
  // load extraction from the registered word; a faulted access yields zero
  always_comb begin
    ld_b = rdata[{off_q, 3'b000} +: 8];
    ld_h = off_q[1] ? rdata[31:16] : rdata[15:0];
    ld = misaligned_out ? '0 :
         size_q == MEM_SIZE_BYTE ? {{24{!uns_q && ld_b[7]}}, ld_b} :
         size_q == MEM_SIZE_HALF ? {{16{!uns_q && ld_h[15]}}, ld_h} : rdata;
    wb_write_data_out = sel_ld_q ? ld : pass_q;
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against a byte-addressed memory model
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] alu_result_in, read_data_2_in, pc_plus_4_in;
  logic [4:0] write_register_in;
  logic reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, is_jal_in, mem_unsigned_in;
  logic [1:0] mem_size_in;
  logic [7:0] dbg_addr_in;
  logic [31:0] dbg_data_out, wb_write_data_out, mem_fwd_data_out;
  logic [4:0] wb_write_register_out;
  logic wb_reg_write_out, misaligned_out;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rg;
    logic        rw;
    logic        mis;
    logic [31:0] dbg;
    logic        cd;
  } exp_t;

  exp_t q[$];
  logic [7:0] mb [1024];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .alu_result_in(alu_result_in), .read_data_2_in(read_data_2_in),
    .write_register_in(write_register_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .is_jal_in(is_jal_in),
    .pc_plus_4_in(pc_plus_4_in), .mem_size_in(mem_size_in),
    .mem_unsigned_in(mem_unsigned_in), .dbg_addr_in(dbg_addr_in),
    .dbg_data_out(dbg_data_out), .wb_write_data_out(wb_write_data_out),
    .wb_write_register_out(wb_write_register_out), .wb_reg_write_out(wb_reg_write_out),
    .mem_fwd_data_out(mem_fwd_data_out), .misaligned_out(misaligned_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // one access: drive, check forwarding, model the response, queue it after the capturing edge
  task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                    input logic rd, input logic wr, input logic m2r, input logic uns,
                    input logic jal, input logic rw, input logic [4:0] rg,
                    input logic [31:0] pc4, input logic [7:0] dba, input logic rs, input logic cd);
    exp_t e;
    logic m;
    logic [31:0] v;
    int n, b0, d;
    reset = rs; alu_result_in = a; read_data_2_in = wd; mem_size_in = sz;
    mem_read_in = rd; mem_write_in = wr; mem_to_reg_in = m2r; mem_unsigned_in = uns;
    is_jal_in = jal; reg_write_in = rw; write_register_in = rg; pc_plus_4_in = pc4;
    dbg_addr_in = dba;
    #1;
    chk("fwd", mem_fwd_data_out, jal ? pc4 : a);
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    b0 = int'(a[9:0]) & ~(n - 1);
    m = (rd || wr) && (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00));
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[b0 + i];
    if (!uns && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!uns && n == 2) v = {{16{v[15]}}, v[15:0]};
    if (m) v = '0;
    d = int'(dba) * 4;
    e.dbg = {mb[d+3], mb[d+2], mb[d+1], mb[d]};
    e.cd = cd;
    if (rs) begin
      e.data = '0; e.rg = '0; e.rw = 1'b0; e.mis = 1'b0; e.dbg = '0;
    end else begin
      e.data = jal ? pc4 : m2r ? v : a;
      e.rg = rg; e.rw = rw && !m; e.mis = m;
      if (wr && !m) for (int i = 0; i < n; i++) mb[b0 + i] = wd[8*i +: 8];
    end
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  // monitor: every cycle the DUT presents one MEM/WB result, compare it with the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wb_data", wb_write_data_out, e.data);
      chk("wb_reg", {27'b0, wb_write_register_out}, {27'b0, e.rg});
      chk("wb_rw", {31'b0, wb_reg_write_out}, {31'b0, e.rw});
      chk("misaligned", {31'b0, misaligned_out}, {31'b0, e.mis});
      if (e.cd) chk("dbg", dbg_data_out, e.dbg);
    end
  end

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    int k, n;
    op(0, 0, 2, 0, 1, 0, 0, 0, 1, 7, 0, 0, 1, 1);
    for (int i = 0; i < 256; i++)
      op(i * 4, $urandom, 2, 0, 1, 0, 0, 0, 0, 0, 0, 8'(i), 0, 0);
    op(32'h10, 32'hDEADBEEF, 2, 0, 1, 0, 0, 0, 0, 0, 0, 8'h04, 0, 1);
    op(32'h10, 0, 2, 1, 0, 1, 0, 0, 1, 5, 0, 8'h04, 0, 1);
    op(32'h13, 0, 0, 1, 0, 1, 0, 0, 1, 6, 0, 8'h04, 0, 1);
    op(32'h13, 0, 0, 1, 0, 1, 1, 0, 1, 6, 0, 8'h04, 0, 1);
    op(32'h12, 0, 1, 1, 0, 1, 0, 0, 1, 6, 0, 8'h04, 0, 1);
    op(32'h11, 32'h55, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h04, 0, 1);
    op(32'h10, 0, 2, 1, 0, 1, 0, 0, 1, 9, 0, 8'h04, 0, 1);
    op(32'h22, 32'hCAFEF00D, 2, 0, 1, 0, 0, 0, 0, 0, 0, 8'h08, 0, 1);
    op(32'h21, 0, 1, 1, 0, 1, 0, 0, 1, 3, 0, 8'h08, 0, 1);
    op(32'hFFFF_FF23, 0, 3, 0, 0, 0, 0, 0, 1, 4, 0, 8'h08, 0, 1);
    op(32'h1234, 0, 2, 0, 0, 0, 0, 1, 1, 31, 32'h408, 8'h08, 0, 1);
    op(32'h10, 32'h12345678, 2, 0, 1, 0, 0, 0, 1, 2, 0, 8'h04, 1, 1);
    op(32'h10, 0, 2, 1, 0, 1, 0, 0, 1, 2, 0, 8'h04, 0, 1);
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 2));
      if (k <= 6 && $urandom_range(0, 15) == 0) sz = 2'd3;
      n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      op(a, $urandom, sz, k <= 3, k >= 4 && k <= 6, k <= 3 || (k == 8 && $urandom_range(0, 1) == 1),
         1'($urandom), k == 8, k <= 3 || k >= 7, 5'($urandom), $urandom,
         $urandom_range(0, 1) == 1 ? a[9:2] : 8'($urandom),
         $urandom_range(0, 39) == 0, 1);
    end
    op(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have input ports alu_result_in (32) = effective address or ALU result; read_data_2_in (32) = store data; write_register_in (5) = destination register.
REQ-004 SHALL have input ports reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, is_jal_in (1 each); pc_plus_4_in (32) = JAL/JALR return value.
REQ-005 SHALL have input ports mem_size_in (2) = 00 byte, 01 half, 10 word, 11 reserved; mem_unsigned_in (1) = zero-extend loads when 1.
REQ-006 SHALL have input port dbg_addr_in (8) = debug word index; output dbg_data_out (32) = memory word at that index, registered.
REQ-007 SHALL have outputs wb_write_data_out (32), wb_write_register_out (5), wb_reg_write_out (1) = MEM/WB results to the register file.
REQ-008 SHALL have output mem_fwd_data_out (32), combinational = is_jal_in ? pc_plus_4_in : alu_result_in, for the forwarding unit.
REQ-009 SHALL have output misaligned_out (1) = one-cycle alignment-fault flag.

Function
REQ-010 SHALL contain 256 x 32 data memory, word index = alu_result_in[9:2]; bits 31:10 ignored; byte lanes little-endian (offset 0 = bits 7:0).
REQ-011 SHALL flag misalignment when a mem_read_in or mem_write_in access has half with addr[0]=1, word with addr[1:0]!=00, or mem_size_in=11.
REQ-012 SHALL write on the rising edge when mem_write_in=1 and not misaligned: byte -> lane addr[1:0] gets read_data_2_in[7:0]; half -> lanes {addr[1],0} and +1 get read_data_2_in[15:0]; word -> all lanes; other lanes unchanged.
REQ-013 SHALL read memory synchronously; load result SHALL be extracted from the registered word using the registered offset, size and unsigned flag.
REQ-014 SHALL sign-extend byte/half loads when mem_unsigned_in=0 and zero-extend when 1; a word load passes 32 bits unchanged.
REQ-015 SHALL produce wb_write_data_out one cycle after inputs are presented: is_jal ? pc_plus_4 : mem_to_reg ? load data : alu_result (priority in that order).
REQ-016 SHALL register wb_write_register_out and wb_reg_write_out with one-cycle latency.
REQ-017 SHALL, on misalignment, suppress the store, force wb_reg_write_out=0, force load data to 0, and assert misaligned_out for exactly the following cycle.
REQ-018 SHALL return new data on a load of the same word in the cycle after a store (no stale read).
REQ-019 SHALL not flag misalignment when mem_read_in=mem_write_in=0, regardless of address.
REQ-020 SHALL update dbg_data_out every cycle from dbg_addr_in, independently of pipeline traffic; on a same-cycle write to that word it SHALL return the old contents.

Reset
REQ-021 SHALL, on reset, clear wb_write_data_out, wb_write_register_out, misaligned_out, dbg_data_out to 0 and drive wb_reg_write_out to CTRL_REG_WRITE_DIS.
REQ-022 SHALL block memory writes during any reset cycle, including a reset asserted mid-sequence; memory contents SHALL otherwise be preserved across reset.
REQ-023 SHALL start operation in the first cycle after reset deasserts, with no extra latency.

Structure
REQ-024 SHALL take DATA_WIDTH, REG_ADDR_WIDTH, CTRL_REG_WRITE_DIS and CTRL_MEM_TO_REG_ALU from mips_pkg.vh.
REQ-025 SHALL add to mips_pkg.vh: MEM_SIZE_BYTE/HALF/WORD encodings and DMEM_DEPTH=256.
REQ-026 SHALL instantiate one sub-module, data_memory (byte-enable write port plus pipeline read port and debug read port); alignment, extraction and the MEM/WB registers SHALL stay in mem_stage.

Verification
REQ-027 Word store 0xDEADBEEF at address 0x10, then word load 0x10 with mem_to_reg=1 in the next cycle -> wb_write_data_out=0xDEADBEEF one cycle later, wb_reg_write_out=1.
REQ-028 Byte load of that word at address 0x13, signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; half load at 0x12, signed -> 0xFFFFDEAD.
REQ-029 Byte store 0x55 at 0x11 over 0xDEADBEEF -> word load returns 0xDEAD55EF.
REQ-030 Word store at 0x22 -> memory unchanged, misaligned_out=1 for one cycle; half load at 0x21 -> wb_reg_write_out=0.
REQ-031 JAL with pc_plus_4_in=0x00000408, write_register_in=31 -> mem_fwd_data_out=0x408 same cycle; wb_write_data_out=0x408 and register 31 next cycle.
REQ-032 Reset asserted during a store cycle -> no write (debug read of that word unchanged); all outputs at reset values.
